systolic_pe_v2: RTL and testbench

- Parametrised successor of the array's single-mode processing element.
- Signed-integer MAC cell for the systolic array, tiled in a 2-D grid with left-to-right operand flow and top-to-bottom partial-sum/weight flow.
- Adds four modes: weight load, weight-stationary (WS) compute, output-stationary (OS) compute, and accumulator drain.
- Adds double-buffered weights, valid qualifiers, a configurable MAC pipeline depth and optional saturation.

---
 rtl/systolic_pe_v2_if.sv | 36 +++
 rtl/systolic_pe_v2.sv | 157 +++++++++++++++
 tb/tb_systolic_pe_v2.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pe_v2_if.sv
// systolic_pe_v2_if: operand, psum and qualifier bundle around one PE.
// master drives the i_* side; slave is the processing element.
interface systolic_pe_v2_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  logic [1:0]        i_mode;
  logic              i_swap;
  logic [ACC_W-1:0]  i_top;
  logic              i_top_valid;
  logic [DATA_W-1:0] i_left;
  logic              i_left_valid;
  logic [ACC_W-1:0]  o_bot;
  logic              o_bot_valid;
  logic [DATA_W-1:0] o_right;
  logic              o_right_valid;
  logic              o_busy;

  modport master (
    output i_mode, i_swap,
    output i_top, i_top_valid,
    output i_left, i_left_valid,
    input  o_bot, o_bot_valid,
    input  o_right, o_right_valid,
    input  o_busy
  );

  modport slave (
    input  i_mode, i_swap,
    input  i_top, i_top_valid,
    input  i_left, i_left_valid,
    output o_bot, o_bot_valid,
    output o_right, o_right_valid,
    output o_busy
  );
endinterface

// File: rtl/systolic_pe_v2.sv
// systolic_pe_v2: signed MAC cell for a 2-D systolic array.
// Modes: weight load, weight-stationary, output-stationary, drain.
module systolic_pe_v2 #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 32,
  parameter int MUL_LAT = 2,
  parameter bit SAT_EN  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  systolic_pe_v2_if.slave pe
);
  localparam int PW = 2 * DATA_W;
  localparam int PD = MUL_LAT - 1;

  typedef enum logic [1:0] {
    M_LOAD  = 2'b00,
    M_WS    = 2'b01,
    M_OS    = 2'b10,
    M_DRAIN = 2'b11
  } mode_e;

  mode_e                    w_mode;
  logic signed [DATA_W-1:0] r_shadow;
  logic signed [DATA_W-1:0] r_active;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_drained;
  logic                     w_iss;
  logic signed [DATA_W-1:0] w_ma;
  logic signed [DATA_W-1:0] w_mb;
  logic signed [PW-1:0]     w_prod;
  logic                     w_tv;
  logic                     w_tws;
  logic signed [PW-1:0]     w_tp;
  logic signed [ACC_W-1:0]  w_ta;
  logic                     w_busy;
  logic signed [ACC_W-1:0]  w_ws_res;
  logic signed [ACC_W-1:0]  w_os_res;

  function automatic logic signed [ACC_W-1:0] f_fit(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (SAT_EN && (s[ACC_W] != s[ACC_W-1]))
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                      : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  assign w_mode = mode_e'(pe.i_mode);
  assign w_iss  = pe.i_left_valid & pe.i_top_valid &
                  (w_mode == M_WS || w_mode == M_OS);
  assign w_ma   = pe.i_left;
  assign w_mb   = (w_mode == M_WS) ? r_active
                                   : pe.i_top[DATA_W-1:0];
  assign w_prod = PW'(w_ma) * PW'(w_mb);

  // weight is folded into the product at issue, so later swaps cannot leak in
  if (PD == 0) begin : g_direct
    assign w_tv   = w_iss;
    assign w_tws  = (w_mode == M_WS);
    assign w_tp   = w_prod;
    assign w_ta   = pe.i_top;
    assign w_busy = 1'b0;
  end else begin : g_pipe
    logic [PD-1:0]           r_v;
    logic [PD-1:0]           r_ws;
    logic signed [PW-1:0]    r_p [PD];
    logic signed [ACC_W-1:0] r_a [PD];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_v  <= '0;
        r_ws <= '0;
        for (int i = 0; i < PD; i++) begin
          r_p[i] <= '0;
          r_a[i] <= '0;
        end
      end else begin
        r_v[0]  <= w_iss;
        r_ws[0] <= (w_mode == M_WS);
        r_p[0]  <= w_prod;
        r_a[0]  <= pe.i_top;
        for (int i = 1; i < PD; i++) begin
          r_v[i]  <= r_v[i-1];
          r_ws[i] <= r_ws[i-1];
          r_p[i]  <= r_p[i-1];
          r_a[i]  <= r_a[i-1];
        end
      end
    end

    assign w_tv   = r_v[PD-1];
    assign w_tws  = r_ws[PD-1];
    assign w_tp   = r_p[PD-1];
    assign w_ta   = r_a[PD-1];
    assign w_busy = |r_v;
  end

  assign w_ws_res = f_fit(w_ta, ACC_W'(w_tp));
  assign w_os_res = f_fit(r_acc, ACC_W'(w_tp));
  assign pe.o_busy = w_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe.o_right       <= '0;
      pe.o_right_valid <= 1'b0;
      pe.o_bot         <= '0;
      pe.o_bot_valid   <= 1'b0;
      r_shadow         <= '0;
      r_active         <= '0;
      r_acc            <= '0;
      r_drained        <= 1'b0;
    end else begin
      pe.o_right       <= pe.i_left;
      pe.o_right_valid <= pe.i_left_valid;
      if (pe.i_swap)
        r_active <= r_shadow;
      if (w_mode == M_LOAD && pe.i_top_valid)
        r_shadow <= pe.i_top[DATA_W-1:0];
      if (w_tv && !w_tws)
        r_acc <= w_os_res;
      r_drained <= 1'b0;
      unique case (w_mode)
        M_LOAD: begin
          pe.o_bot <= ACC_W'(pe.i_top[DATA_W-1:0]);
          pe.o_bot_valid <= pe.i_top_valid;
        end
        M_WS: begin
          pe.o_bot_valid <= w_tv & w_tws;
          if (w_tv && w_tws)
            pe.o_bot <= w_ws_res;
        end
        M_OS: begin
          pe.o_bot       <= pe.i_top;
          pe.o_bot_valid <= pe.i_top_valid;
        end
        M_DRAIN: begin
          r_drained <= r_drained;
          if (r_drained) begin
            pe.o_bot       <= pe.i_top;
            pe.o_bot_valid <= pe.i_top_valid;
          end else if (w_busy) begin
            pe.o_bot_valid <= 1'b0;
          end else begin
            pe.o_bot       <= r_acc;
            pe.o_bot_valid <= 1'b1;
            r_acc          <= '0;
            r_drained      <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_pe_v2.sv
// tb_systolic_pe_v2: two PEs (sat/lat2, wrap/lat3) on shared stimulus,
// checked against a queue-based arithmetic model.
`timescale 1ns/1ps
module tb_systolic_pe_v2;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam logic [1:0] LD = 2'b00;
  localparam logic [1:0] WS = 2'b01;
  localparam logic [1:0] OS = 2'b10;
  localparam logic [1:0] DR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_pe_v2_if #(.DATA_W(DW), .ACC_W(AW)) if0 ();
  systolic_pe_v2_if #(.DATA_W(DW), .ACC_W(AW)) if1 ();

  systolic_pe_v2 #(
    .DATA_W(DW), .ACC_W(AW), .MUL_LAT(2), .SAT_EN(1'b1)
  ) u_pe0 (.clk(clk), .rst(rst), .pe(if0));

  systolic_pe_v2 #(
    .DATA_W(DW), .ACC_W(AW), .MUL_LAT(3), .SAT_EN(1'b0)
  ) u_pe1 (.clk(clk), .rst(rst), .pe(if1));

  typedef struct {
    int     k;
    int     due;
    bit     ws;
    longint v;
  } pend_t;

  pend_t          q[$];
  logic [DW-1:0]  m_sh  [2];
  logic [DW-1:0]  m_act [2];
  longint         m_acc [2];
  bit             m_drn [2];
  logic [AW-1:0]  m_bot [2];
  bit             m_bv  [2];
  logic [DW-1:0]  m_right;
  bit             m_rv;
  int             ncyc = 0;
  int             checks = 0;
  int             failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic longint fit(input longint s, input bit sat);
    longint mx;
    longint mn;
    logic signed [AW-1:0] t;
    mx = (longint'(1) <<< (AW - 1)) - 1;
    mn = -(longint'(1) <<< (AW - 1));
    if (sat) begin
      if (s > mx) return mx;
      if (s < mn) return mn;
      return s;
    end
    t = s[AW-1:0];
    return longint'(t);
  endfunction

  function automatic bit q_busy(input int k);
    foreach (q[j]) if (q[j].k == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    q.delete();
    for (int k = 0; k < 2; k++) begin
      m_sh[k] = '0; m_act[k] = '0; m_acc[k] = 0;
      m_drn[k] = 0; m_bot[k] = '0; m_bv[k] = 0;
    end
    m_right = '0;
    m_rv = 0;
  endtask

  task automatic m_step(input logic [1:0] md, input bit sw,
                        input logic [AW-1:0] tp, input bit tv,
                        input logic [DW-1:0] lf, input bit lv);
    longint l_s;
    longint t_s;
    longint tl_s;
    l_s  = longint'($signed(lf));
    t_s  = longint'($signed(tp));
    tl_s = longint'($signed(tp[DW-1:0]));
    for (int k = 0; k < 2; k++) begin
      bit     infl;
      bit     done;
      longint dv;
      pend_t  e;
      infl = q_busy(k);
      done = 0;
      dv   = 0;
      if (lv && tv && (md == WS || md == OS)) begin
        e.k   = k;
        e.due = ncyc + lat(k) - 1;
        e.ws  = (md == WS);
        e.v   = e.ws ? t_s + l_s * longint'($signed(m_act[k]))
                     : l_s * tl_s;
        q.push_back(e);
      end
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (q[j].k == k && q[j].due == ncyc) begin
          if (q[j].ws) begin
            done = 1;
            dv   = fit(q[j].v, k == 0);
          end else begin
            m_acc[k] = fit(m_acc[k] + q[j].v, k == 0);
          end
          q.delete(j);
        end
      end
      case (md)
        LD: begin
          m_bot[k] = {{(AW-DW){1'b0}}, tp[DW-1:0]};
          m_bv[k]  = tv;
        end
        WS: begin
          m_bv[k] = done;
          if (done) m_bot[k] = dv[AW-1:0];
        end
        OS: begin
          m_bot[k] = tp;
          m_bv[k]  = tv;
        end
        default: begin
          if (m_drn[k]) begin
            m_bot[k] = tp;
            m_bv[k]  = tv;
          end else if (infl) begin
            m_bv[k] = 0;
          end else begin
            m_bot[k] = m_acc[k][AW-1:0];
            m_bv[k]  = 1;
            m_acc[k] = 0;
            m_drn[k] = 1;
          end
        end
      endcase
      if (md != DR) m_drn[k] = 0;
      if (sw) m_act[k] = m_sh[k];
      if (md == LD && tv) m_sh[k] = tp[DW-1:0];
    end
    m_right = lf;
    m_rv    = lv;
    ncyc++;
  endtask

  task automatic check_all();
    chk("right0", if0.o_right, m_right);
    chk("rv0", if0.o_right_valid, m_rv);
    chk("right1", if1.o_right, m_right);
    chk("rv1", if1.o_right_valid, m_rv);
    chk("bv0", if0.o_bot_valid, m_bv[0]);
    chk("bv1", if1.o_bot_valid, m_bv[1]);
    chk("busy0", if0.o_busy, q_busy(0));
    chk("busy1", if1.o_busy, q_busy(1));
    if (m_bv[0]) chk("bot0", if0.o_bot, m_bot[0]);
    if (m_bv[1]) chk("bot1", if1.o_bot, m_bot[1]);
  endtask

  task automatic drive(input logic [1:0] md, input bit sw,
                       input logic [AW-1:0] tp, input bit tv,
                       input logic [DW-1:0] lf, input bit lv);
    if0.i_mode = md; if0.i_swap = sw;
    if0.i_top = tp; if0.i_top_valid = tv;
    if0.i_left = lf; if0.i_left_valid = lv;
    if1.i_mode = md; if1.i_swap = sw;
    if1.i_top = tp; if1.i_top_valid = tv;
    if1.i_left = lf; if1.i_left_valid = lv;
  endtask

  task automatic cyc(input logic [1:0] md, input bit sw,
                     input logic [AW-1:0] tp, input bit tv,
                     input logic [DW-1:0] lf, input bit lv);
    drive(md, sw, tp, tv, lf, lv);
    @(posedge clk);
    #1;
    m_step(md, sw, tp, tv, lf, lv);
    check_all();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bot0"}, if0.o_bot, 0);
    chk({tag, "_bv0"}, if0.o_bot_valid, 0);
    chk({tag, "_r0"}, if0.o_right, 0);
    chk({tag, "_rv0"}, if0.o_right_valid, 0);
    chk({tag, "_busy0"}, if0.o_busy, 0);
    chk({tag, "_bot1"}, if1.o_bot, 0);
    chk({tag, "_busy1"}, if1.o_busy, 0);
    chk({tag, "_rv1"}, if1.o_right_valid, 0);
  endtask

  initial begin
    logic [1:0] md;
    int         run;
    bit         act;
    m_reset();
    drive(LD, 0, '0, 0, '0, 0);
    #12;
    chk_zero("rst");
    rst = 1'b1;

    // weight load, swap, WS op: 100 + (-2)*3 = 94
    cyc(LD, 0, 32'h3, 1, 16'h0, 0);
    cyc(LD, 1, 32'h0, 0, 16'h0, 0);
    cyc(WS, 0, 32'd100, 1, 16'hFFFE, 1);
    chk("ws_right", if0.o_right, 16'hFFFE);
    cyc(WS, 0, 32'h0, 0, 16'h0, 0);
    chk("ws_94_v", if0.o_bot_valid, 1);
    chk("ws_94", if0.o_bot, 32'd94);
    cyc(WS, 0, 32'h0, 0, 16'h0, 0);

    // swap with simultaneous load
    cyc(LD, 0, 32'h5, 1, 16'h0, 0);
    cyc(LD, 1, 32'h7, 1, 16'h0, 0);
    cyc(WS, 0, 32'h0, 1, 16'h1, 1);
    cyc(WS, 0, 32'h0, 0, 16'h0, 0);
    chk("swap_5", if0.o_bot, 32'd5);
    cyc(WS, 0, 32'h0, 0, 16'h0, 0);
    cyc(WS, 1, 32'h0, 0, 16'h0, 0);
    cyc(WS, 0, 32'h0, 1, 16'h1, 1);
    cyc(WS, 0, 32'h0, 0, 16'h0, 0);
    chk("swap_7", if0.o_bot, 32'd7);
    cyc(WS, 0, 32'h0, 0, 16'h0, 0);

    // OS accumulate then drain
    cyc(OS, 0, 32'h2, 1, 16'd10, 1);
    cyc(OS, 0, 32'h3, 1, 16'd10, 1);
    cyc(OS, 0, 32'h4, 1, 16'd10, 1);
    cyc(OS, 0, 32'h0, 0, 16'h0, 0);
    cyc(OS, 0, 32'h0, 0, 16'h0, 0);
    cyc(DR, 0, 32'h0, 0, 16'h0, 0);
    chk("drain_v", if0.o_bot_valid, 1);
    chk("drain_90", if0.o_bot, 32'd90);
    chk("drain_90_w", if1.o_bot, 32'd90);
    cyc(DR, 0, 32'h1234, 1, 16'h0, 0);
    chk("drain_fwd", if0.o_bot, 32'h1234);
    cyc(OS, 0, 32'h0, 0, 16'h0, 0);
    cyc(DR, 0, 32'h0, 0, 16'h0, 0);
    chk("drain_acc0", if0.o_bot, 32'h0);

    // saturation vs wrap
    cyc(LD, 0, 32'h7FFF, 1, 16'h0, 0);
    cyc(LD, 1, 32'h0, 0, 16'h0, 0);
    cyc(WS, 0, 32'h7FFFFFF0, 1, 16'h7FFF, 1);
    cyc(WS, 0, 32'h0, 0, 16'h0, 0);
    chk("sat_max", if0.o_bot, 32'h7FFFFFFF);
    cyc(WS, 0, 32'h0, 0, 16'h0, 0);
    chk("wrap", if1.o_bot, 32'hBFFEFFF1);

    // left valid alone never issues
    for (int i = 0; i < 4; i++) begin
      cyc(WS, 0, 32'h0, 0, 16'(i + 1), 1);
      chk("lonly_busy", if0.o_busy, 0);
      chk("lonly_bv", if0.o_bot_valid, 0);
    end

    // async reset mid-pipeline
    cyc(WS, 0, 32'd9, 1, 16'd3, 1);
    drive(WS, 0, '0, 0, '0, 0);
    #2 rst = 1'b0;
    #1 chk_zero("arst");
    #1 rst = 1'b1;
    m_reset();
    for (int i = 0; i < 4; i++) cyc(WS, 0, 32'h0, 0, 16'h0, 0);

    // randomized traffic; mode only changes with empty pipelines
    md  = WS;
    run = 0;
    for (int n = 0; n < 1500; n++) begin
      if (run == 0 && q.size() == 0) begin
        md  = 2'($urandom_range(0, 3));
        run = $urandom_range(1, 12);
      end
      act = (run > 0);
      if (run > 0) run--;
      cyc(md, $urandom_range(0, 7) == 0, $urandom,
          act && $urandom_range(0, 3) != 0,
          16'($urandom), act && $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
